// File: rtl/segment_encoder.sv
// segment_encoder: 16-bit value to four active-low seven-segment patterns.
// Decimal conversion is an iterative double-dabble (one shift per clock).
// Hex mode runs the same fixed-latency sequence and then takes nibbles from the
// captured value. Outputs are registered and written together in LATCH.
// Optional feature: define SEGMENT_ENCODER_LZB_EN for leading-zero blanking.
module segment_encoder #(
  parameter int unsigned ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        hex_mode,
  input  logic [3:0]  dp_mask,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  segment_data0,
  output logic [7:0]  segment_data1,
  output logic [7:0]  segment_data2,
  output logic [7:0]  segment_data3
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StLatch = 2'd2;

  localparam logic [7:0] PatDash  = 8'hBF;
  localparam logic [7:0] PatBlank = 8'hFF;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bin_q, bin_d;   // shifting copy of the value
  logic [15:0] val_q, val_d;   // untouched copy for hex mode
  logic [19:0] bcd_q, bcd_d;
  logic        hex_q, hex_d;
  logic [3:0]  dp_q, dp_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  seg_q [4];
  logic [7:0]  seg_d [4];

  logic [19:0] bcd_adj;
  logic [3:0]  digit [4];
  logic        ovf_calc;
  logic [7:0]  pat [4];

  function automatic logic [7:0] font(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Final digit patterns from the completed conversion (used in LATCH).
  always_comb begin
    digit[0] = hex_q ? val_q[15:12] : bcd_q[15:12];
    digit[1] = hex_q ? val_q[11:8]  : bcd_q[11:8];
    digit[2] = hex_q ? val_q[7:4]   : bcd_q[7:4];
    digit[3] = hex_q ? val_q[3:0]   : bcd_q[3:0];
    ovf_calc = !hex_q && (bcd_q[19:16] != 4'd0);
    for (int i = 0; i < 4; i++) begin
      pat[i] = font(digit[i]);
    end
`ifdef SEGMENT_ENCODER_LZB_EN
    // Blank a zero only while every digit to its left is also zero; the
    // rightmost digit is always shown.
    if (!ovf_calc && digit[0] == 4'd0) begin
      pat[0] = PatBlank;
      if (digit[1] == 4'd0) begin
        pat[1] = PatBlank;
        if (digit[2] == 4'd0) pat[2] = PatBlank;
      end
    end
`endif
    for (int i = 0; i < 4; i++) begin
      if (ovf_calc) pat[i] = PatDash;
      if (dp_q[i]) pat[i][7] = 1'b0;
    end
  end

  // Next-state: capture on accepted load, shift 16 times, then latch outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    val_d   = val_q;
    bcd_d   = bcd_q;
    hex_d   = hex_q;
    dp_d    = dp_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < 4; i++) seg_d[i] = seg_q[i];
    case (state_q)
      StIdle: begin
        if (load) begin
          bin_d   = value;
          val_d   = value;
          hex_d   = hex_mode;
          dp_d    = dp_mask;
          bcd_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[18:0], bin_q[15]};
        bin_d = {bin_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) state_d = StLatch;
      end
      StLatch: begin
        for (int i = 0; i < 4; i++) seg_d[i] = pat[i];
        ovf_d   = ovf_calc;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      bin_q   <= 16'd0;
      val_q   <= 16'd0;
      bcd_q   <= 20'd0;
      hex_q   <= 1'b0;
      dp_q    <= 4'd0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < 4; i++) seg_q[i] <= PatBlank;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      val_q   <= val_d;
      bcd_q   <= bcd_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 4; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign busy          = (state_q != StIdle);
  assign overflow      = ovf_q;
  assign segment_data0 = seg_q[0];
  assign segment_data1 = seg_q[1];
  assign segment_data2 = seg_q[2];
  assign segment_data3 = seg_q[3];

endmodule

// File: tb/tb_segment_encoder.sv
// Directed-vector bench for segment_encoder. Expected patterns are hand-computed
// from the font table; define SEGMENT_ENCODER_LZB_EN to match a blanking build.
module tb_segment_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        hex_mode;
  logic [3:0]  dp_mask;
  logic        load;
  logic        busy;
  logic        overflow;
  logic [7:0]  segment_data0, segment_data1, segment_data2, segment_data3;

  int n_vec = 0;
  int n_err = 0;

  segment_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .value         (value),
    .hex_mode      (hex_mode),
    .dp_mask       (dp_mask),
    .load          (load),
    .busy          (busy),
    .overflow      (overflow),
    .segment_data0 (segment_data0),
    .segment_data1 (segment_data1),
    .segment_data2 (segment_data2),
    .segment_data3 (segment_data3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] segs();
    return {segment_data0, segment_data1, segment_data2, segment_data3};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Launch one conversion and follow it to completion. If pulse_at is nonzero a
  // second load carrying pulse_val is raised after that many busy cycles.
  task automatic run(input string tag, input logic [15:0] v, input logic h,
                     input logic [3:0] dp, input logic [31:0] exp_seg,
                     input logic exp_ovf, input int pulse_at,
                     input logic [15:0] pulse_val);
    logic [31:0] prev_seg;
    logic        prev_ovf;
    logic        held_bad;
    int          cyc;
    prev_seg = segs();
    prev_ovf = overflow;
    held_bad = 1'b0;
    value    = v;
    hex_mode = h;
    dp_mask  = dp;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (pulse_at != 0 && cyc == pulse_at) begin
        value = pulse_val;
        load  = 1'b1;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      cyc++;
      if (!busy) break;
      if (segs() !== prev_seg || overflow !== prev_ovf) held_bad = 1'b1;
    end
    check({tag, " latency"}, 32'(cyc), 32'd17);
    check({tag, " held"}, 32'(held_bad), 32'd0);
    check({tag, " segs"}, segs(), exp_seg);
    check({tag, " ovf"}, 32'(overflow), 32'(exp_ovf));
  endtask

  initial begin
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'd0;
    hex_mode = 1'b0;
    dp_mask  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset segs", segs(), 32'hFFFF_FFFF);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ovf", 32'(overflow), 32'd0);

    run("dec1234", 16'd1234, 1'b0, 4'b0000, 32'hF9A4_B099, 1'b0, 0, 16'd0);
    run("dec10000", 16'd10000, 1'b0, 4'b0000, 32'hBFBF_BFBF, 1'b1, 0, 16'd0);
    run("dec9999", 16'd9999, 1'b0, 4'b0000, 32'h9090_9090, 1'b0, 0, 16'd0);
    run("dec65535", 16'd65535, 1'b0, 4'b1001, 32'h3FBF_BF3F, 1'b1, 0, 16'd0);
    run("hexFFFF", 16'hFFFF, 1'b1, 4'b0000, 32'h8E8E_8E8E, 1'b0, 0, 16'd0);
    run("hexBEEF", 16'hBEEF, 1'b1, 4'b0110, 32'h8306_068E, 1'b0, 0, 16'd0);
`ifdef SEGMENT_ENCODER_LZB_EN
    run("dec7", 16'd7, 1'b0, 4'b0000, 32'hFFFF_FFF8, 1'b0, 0, 16'd0);
    run("dec7dp", 16'd7, 1'b0, 4'b1001, 32'h7FFF_FF78, 1'b0, 0, 16'd0);
    run("dec0", 16'd0, 1'b0, 4'b0000, 32'hFFFF_FFC0, 1'b0, 0, 16'd0);
    run("hex00A5", 16'h00A5, 1'b1, 4'b0000, 32'hFFFF_8892, 1'b0, 0, 16'd0);
    run("dec42pulse", 16'd42, 1'b0, 4'b0000, 32'hFFFF_99A4, 1'b0, 6, 16'd55);
`else
    run("dec7", 16'd7, 1'b0, 4'b0000, 32'hC0C0_C0F8, 1'b0, 0, 16'd0);
    run("dec7dp", 16'd7, 1'b0, 4'b1001, 32'h40C0_C078, 1'b0, 0, 16'd0);
    run("dec0", 16'd0, 1'b0, 4'b0000, 32'hC0C0_C0C0, 1'b0, 0, 16'd0);
    run("hex00A5", 16'h00A5, 1'b1, 4'b0000, 32'hC0C0_8892, 1'b0, 0, 16'd0);
    run("dec42pulse", 16'd42, 1'b0, 4'b0000, 32'hC0C0_99A4, 1'b0, 6, 16'd55);
`endif
    // No conversion may follow the ignored second load.
    repeat (20) @(posedge clk);
    #1;
    check("no_requeue busy", 32'(busy), 32'd0);

    // Reset in the middle of a conversion.
    run("dec1234b", 16'd1234, 1'b0, 4'b0000, 32'hF9A4_B099, 1'b0, 0, 16'd0);
    value = 16'd10000;
    load  = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst segs", segs(), 32'hFFFF_FFFF);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ovf", 32'(overflow), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    check("midrst later segs", segs(), 32'hFFFF_FFFF);
    check("midrst later ovf", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
